// File: rtl/reg_pkg.sv
// reg_pkg: shared widths, zero-register index and index-width helper for the register write arbiter
package reg_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEF_NUM_REQ = 3;
  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/reg_wr_rr_pick.sv
// reg_wr_rr_pick: combinational rotating-priority picker
//   i_valid : request vector
//   i_ptr   : highest-priority index this cycle
//   o_grant : one-hot grant (zero when nothing valid)
//   o_idx   : index of the granted request
//   o_any   : some request is valid
module reg_wr_rr_pick
  import reg_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IW = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [IW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IW-1:0]      o_idx,
  output logic               o_any
);
  int w_j;
  // Walk from the farthest offset back to the pointer so the closest valid request wins.
  always_comb begin
    o_grant = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_j = int'(i_ptr) + k;
      if (w_j >= NUM_REQ) w_j = w_j - NUM_REQ;
      if (i_valid[w_j]) begin
        o_grant = '0;
        o_grant[w_j] = 1'b1;
        o_idx = IW'(w_j);
        o_any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/reg_wr_arbiter.sv
// reg_wr_arbiter: round-robin arbiter sharing one register-file write port among writeback requesters
//   i_clk, i_areset (async, active-low)
//   i_req_valid/i_req_addr/i_req_data : packed per-requester writes, o_req_ready : one-hot accept
//   i_flush : drop this cycle's requests and reset priority
//   o_wr_en/o_wr_addr/o_wr_data/o_grant_id : registered write port and last accepted requester
//   o_conflict_cnt : saturating count of contended cycles
module reg_wr_arbiter
  import reg_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W = reg_pkg::DATA_W,
  parameter int ADDR_W = reg_pkg::ADDR_W,
  parameter int CNT_W = 16,
  parameter int IW = idx_w(NUM_REQ)
) (
  input  logic                      i_clk,
  input  logic                      i_areset,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
  output logic [NUM_REQ-1:0]        o_req_ready,
  input  logic                      i_flush,
  output logic                      o_wr_en,
  output logic [ADDR_W-1:0]         o_wr_addr,
  output logic [DATA_W-1:0]         o_wr_data,
  output logic [IW-1:0]             o_grant_id,
  output logic [CNT_W-1:0]          o_conflict_cnt
);
  logic [IW-1:0]      r_ptr;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_wr_en;
  logic [ADDR_W-1:0]  r_wr_addr;
  logic [DATA_W-1:0]  r_wr_data;
  logic [IW-1:0]      r_grant_id;
  logic [NUM_REQ-1:0] w_grant;
  logic [IW-1:0]      w_idx;
  logic               w_any;
  logic               w_xfer;
  logic               w_contend;
  logic [ADDR_W-1:0]  w_addr;
  logic [DATA_W-1:0]  w_data;
  reg_wr_rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .i_valid(i_req_valid),
    .i_ptr(r_ptr),
    .o_grant(w_grant),
    .o_idx(w_idx),
    .o_any(w_any)
  );
  assign o_req_ready = i_flush ? '0 : w_grant;
  assign w_xfer = w_any & ~i_flush;
  assign w_contend = ~i_flush & ($countones(i_req_valid) >= 2);
  assign w_addr = i_req_addr[int'(w_idx)*ADDR_W +: ADDR_W];
  assign w_data = i_req_data[int'(w_idx)*DATA_W +: DATA_W];
  always_ff @(posedge i_clk or negedge i_areset) begin
    if (!i_areset) begin
      r_ptr <= '0;
      r_cnt <= '0;
      r_wr_en <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_grant_id <= '0;
    end else begin
      // Zero-register writes are still accepted and recorded, only the enable is suppressed.
      r_wr_en <= w_xfer && (w_addr != ADDR_W'(ZERO_REG));
      if (w_xfer) begin
        r_wr_addr <= w_addr;
        r_wr_data <= w_data;
        r_grant_id <= w_idx;
      end
      r_ptr <= i_flush ? '0 : !w_xfer ? r_ptr : (w_idx == IW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
      if (w_contend && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end
  end
  assign o_wr_en = r_wr_en;
  assign o_wr_addr = r_wr_addr;
  assign o_wr_data = r_wr_data;
  assign o_grant_id = r_grant_id;
  assign o_conflict_cnt = r_cnt;
endmodule

// File: tb/tb_reg_wr_arbiter.sv
// tb_reg_wr_arbiter: directed self-checking bench for reg_wr_arbiter
module tb_reg_wr_arbiter;
  logic         clk = 1'b0;
  logic         areset = 1'b0;
  logic [2:0]   req_valid = '0;
  logic [14:0]  req_addr = '0;
  logic [95:0]  req_data = '0;
  logic         flush = 1'b0;
  logic [2:0]   req_ready;
  logic         wr_en;
  logic [4:0]   wr_addr;
  logic [31:0]  wr_data;
  logic [1:0]   grant_id;
  logic [15:0]  conflict_cnt;
  logic [2:0]   req_ready4;
  logic         wr_en4;
  logic [4:0]   wr_addr4;
  logic [31:0]  wr_data4;
  logic [1:0]   grant_id4;
  logic [3:0]   conflict_cnt4;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  reg_wr_arbiter #(.NUM_REQ(3), .CNT_W(16)) dut (
    .i_clk(clk), .i_areset(areset), .i_req_valid(req_valid), .i_req_addr(req_addr),
    .i_req_data(req_data), .o_req_ready(req_ready), .i_flush(flush), .o_wr_en(wr_en),
    .o_wr_addr(wr_addr), .o_wr_data(wr_data), .o_grant_id(grant_id), .o_conflict_cnt(conflict_cnt)
  );

  reg_wr_arbiter #(.NUM_REQ(3), .CNT_W(4)) dut4 (
    .i_clk(clk), .i_areset(areset), .i_req_valid(req_valid), .i_req_addr(req_addr),
    .i_req_data(req_data), .o_req_ready(req_ready4), .i_flush(flush), .o_wr_en(wr_en4),
    .o_wr_addr(wr_addr4), .o_wr_data(wr_data4), .o_grant_id(grant_id4), .o_conflict_cnt(conflict_cnt4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    flush = 1'b0;
    areset = 1'b0;
    tick();
    areset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    req_valid = 3'b001;
    req_addr[4:0] = 5'd3;
    req_data[31:0] = 32'h5555_AAAA;
    tick();
    req_valid = '0;
    n_chk++;
    if (wr_en !== 1'b1) begin n_fail++; $display("FAIL reset_pre_wr_en got %b exp 1", wr_en); end
    #2;
    areset = 1'b0;
    #1;
    n_chk++;
    if ({wr_en, wr_addr, wr_data, grant_id, conflict_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_async got en=%b addr=%h data=%h gid=%0d cnt=%0d exp all 0", wr_en, wr_addr, wr_data, grant_id, conflict_cnt);
    end
    tick();
    areset = 1'b1;
    tick();
    tick();
    n_chk++;
    if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_idle_wr_en got %b exp 0", wr_en); end
  endtask

  task automatic test_single();
    req_valid = 3'b010;
    req_addr[9:5] = 5'd7;
    req_data[63:32] = 32'hDEAD_BEEF;
    #1;
    n_chk++;
    if (req_ready !== 3'b010) begin n_fail++; $display("FAIL single_ready got %b exp 010", req_ready); end
    tick();
    req_valid = '0;
    n_chk++;
    if ({wr_en, wr_addr, wr_data, grant_id} !== {1'b1, 5'd7, 32'hDEAD_BEEF, 2'd1}) begin
      n_fail++;
      $display("FAIL single_write got en=%b addr=%0d data=%h gid=%0d exp 1/7/deadbeef/1", wr_en, wr_addr, wr_data, grant_id);
    end
    tick();
    n_chk++;
    if (wr_en !== 1'b0 || wr_addr !== 5'd7 || wr_data !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL single_hold got en=%b addr=%0d data=%h exp 0/7/deadbeef", wr_en, wr_addr, wr_data);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    req_addr = {5'd3, 5'd2, 5'd1};
    req_data = {32'hA2, 32'hA1, 32'hA0};
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      #1;
      n_chk++;
      if (req_ready !== 3'(1 << (k % 3))) begin
        n_fail++;
        $display("FAIL rr_ready[%0d] got %b exp %b", k, req_ready, 3'(1 << (k % 3)));
      end
      tick();
      n_chk++;
      if (grant_id !== 2'(k % 3) || wr_addr !== 5'(k % 3 + 1) || wr_data !== 32'(8'hA0 + k % 3) || wr_en !== 1'b1 || conflict_cnt !== 16'(k + 1)) begin
        n_fail++;
        $display("FAIL rr_write[%0d] got gid=%0d addr=%0d data=%h en=%b cnt=%0d exp gid=%0d cnt=%0d", k, grant_id, wr_addr, wr_data, wr_en, conflict_cnt, k % 3, k + 1);
      end
    end
    req_valid = '0;
    tick();
    n_chk++;
    if (conflict_cnt !== 16'd6) begin n_fail++; $display("FAIL rr_cnt_final got %0d exp 6", conflict_cnt); end
  endtask

  task automatic test_zero_reg();
    req_addr[4:0] = 5'd0;
    req_data[31:0] = 32'h1234;
    req_valid = 3'b001;
    #1;
    n_chk++;
    if (req_ready !== 3'b001) begin n_fail++; $display("FAIL zero_ready got %b exp 001", req_ready); end
    tick();
    n_chk++;
    if (wr_en !== 1'b0 || grant_id !== 2'd0 || wr_addr !== 5'd0 || wr_data !== 32'h1234) begin
      n_fail++;
      $display("FAIL zero_write got en=%b gid=%0d addr=%0d data=%h exp 0/0/0/1234", wr_en, grant_id, wr_addr, wr_data);
    end
    req_addr[4:0] = 5'd4;
    req_addr[9:5] = 5'd9;
    req_valid = 3'b011;
    #1;
    n_chk++;
    if (req_ready !== 3'b010) begin n_fail++; $display("FAIL zero_next_ready got %b exp 010", req_ready); end
    tick();
    req_valid = '0;
    n_chk++;
    if (wr_en !== 1'b1 || grant_id !== 2'd1 || wr_addr !== 5'd9 || conflict_cnt !== 16'd7) begin
      n_fail++;
      $display("FAIL zero_next_write got en=%b gid=%0d addr=%0d cnt=%0d exp 1/1/9/7", wr_en, grant_id, wr_addr, conflict_cnt);
    end
  endtask

  task automatic test_flush();
    req_addr = {5'd3, 5'd2, 5'd1};
    req_valid = 3'b111;
    flush = 1'b1;
    #1;
    n_chk++;
    if (req_ready !== 3'b000) begin n_fail++; $display("FAIL flush_ready got %b exp 000", req_ready); end
    tick();
    flush = 1'b0;
    n_chk++;
    if (wr_en !== 1'b0 || conflict_cnt !== 16'd7) begin
      n_fail++;
      $display("FAIL flush_write got en=%b cnt=%0d exp 0/7", wr_en, conflict_cnt);
    end
    #1;
    n_chk++;
    if (req_ready !== 3'b001) begin n_fail++; $display("FAIL flush_after_ready got %b exp 001", req_ready); end
    tick();
    req_valid = '0;
    n_chk++;
    if (wr_en !== 1'b1 || grant_id !== 2'd0 || conflict_cnt !== 16'd8) begin
      n_fail++;
      $display("FAIL flush_after_write got en=%b gid=%0d cnt=%0d exp 1/0/8", wr_en, grant_id, conflict_cnt);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    req_addr = {5'd3, 5'd2, 5'd1};
    req_valid = 3'b011;
    for (int k = 0; k < 20; k++) begin
      tick();
      n_chk++;
      if (conflict_cnt4 !== 4'((k + 1 > 15) ? 15 : k + 1)) begin
        n_fail++;
        $display("FAIL sat_cnt4[%0d] got %0d exp %0d", k, conflict_cnt4, (k + 1 > 15) ? 15 : k + 1);
      end
    end
    req_valid = '0;
    tick();
    n_chk++;
    if (conflict_cnt4 !== 4'hF || conflict_cnt !== 16'd20) begin
      n_fail++;
      $display("FAIL sat_final got cnt4=%0d cnt16=%0d exp 15/20", conflict_cnt4, conflict_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_zero_reg();
    test_flush();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_wr_arbiter.md
Name: reg_wr_arbiter

Overview:
Round-robin arbiter that shares the single register-file write port among NUM_REQ writeback requesters (ALU result, load return, CSR/link write).
- Valid/ready handshake per requester.
- Registered write port output: wr_en, wr_addr, wr_data. This port drives the register file's per-register write_enable/data_in.
- Suppresses writes to the hard-wired zero register.
- Provides a flush input and a saturating contention counter for performance debug.

Parameters:
NUM_REQ, 3, number of writeback requesters (2..8)
DATA_W, 32, register data width
ADDR_W, 5, register index width
CNT_W, 16, contention counter width

Ports:
clk  input  1  rising-edge clock
areset  input  1  asynchronous reset, active-low (asserted when 0)
req_valid  input  NUM_REQ  per-requester write request
req_addr  input  NUM_REQ*ADDR_W  packed destination index; requester i occupies bits [i*ADDR_W +: ADDR_W]
req_data  input  NUM_REQ*DATA_W  packed write data; requester i occupies bits [i*DATA_W +: DATA_W]
req_ready  output  NUM_REQ  per-requester accept, one-hot or zero
flush  input  1  drop all requests this cycle and reset priority
wr_en  output  1  register-file write enable (registered)
wr_addr  output  ADDR_W  register-file write index (registered)
wr_data  output  DATA_W  register-file write data (registered)
grant_id  output  max(1,$clog2(NUM_REQ))  index of last accepted requester (registered)
conflict_cnt  output  CNT_W  saturating count of contended cycles

Behaviour:
- Reset: while areset==0, all state clears asynchronously: wr_en=0, wr_addr=0, wr_data=0, grant_id=0, rr_ptr=0, conflict_cnt=0. An in-flight registered write is dropped; nothing is written.
- Grant selection (combinational):
  - g = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... with wrap mod NUM_REQ.
  - req_ready[g]=1; all other req_ready bits are 0.
  - With no valid request, or flush=1, req_ready=0.
- Handshake:
  - A transfer occurs when req_valid[i] && req_ready[i].
  - A requester holds valid/addr/data stable until accepted and must not withdraw valid before acceptance.
  - req_ready may depend combinationally on req_valid. The requester must not make valid depend on ready.
- Latency: a transfer in cycle N appears on wr_en/wr_addr/wr_data/grant_id in cycle N+1, for exactly one cycle.
  - wr_en is low in any cycle following a cycle with no transfer; wr_addr/wr_data hold their last values.
- Zero register: a transfer with req_addr==0 is accepted (ready=1, pointer advances) but produces wr_en=0 next cycle. wr_addr/wr_data still update; grant_id updates.
- Pointer:
  - After a transfer from g, rr_ptr <= (g+1) mod NUM_REQ.
  - With no transfer, rr_ptr holds.
  - flush=1 forces rr_ptr <= 0.
- Flush: no transfer and wr_en=0 next cycle. Flush takes priority over all requests. conflict_cnt does not count flush cycles.
- Contention: if flush=0 and popcount(req_valid) >= 2, conflict_cnt increments by 1, saturating at all-ones (no wrap).
- Fairness: every continuously-valid requester is accepted within NUM_REQ transfers.
- Throughput: one write accepted per cycle with no bubbles.

Decomposition:
- Shared package reg_pkg holds:
  - DATA_W=32, ADDR_W=5
  - ZERO_REG=5'd0
  - default NUM_REQ
- One sub-module is natural: reg_wr_rr_pick. It is a purely combinational rotating-priority picker.
  - Inputs: valid vector, rr_ptr.
  - Outputs: one-hot grant, grant index, any_grant.
- Top-level reg_wr_arbiter holds:
  - rr_ptr, conflict counter
  - output register stage
  - zero-register and flush gating

Test Plan:
1. Reset: drive areset=0 mid-transfer, with wr_en=1 pending → all outputs 0 immediately, without waiting for a clock edge. Release reset, no requests → wr_en stays 0.
2. Single requester: req_valid=3'b010, addr=7, data=32'hDEAD_BEEF → req_ready=3'b010 same cycle. Next cycle wr_en=1, wr_addr=7, wr_data=32'hDEADBEEF, grant_id=1.
3. Round-robin: all three valid continuously from reset → accept order 0,1,2,0,1,2, one per cycle. conflict_cnt increments by 1 each cycle (6 after 6 cycles).
4. Zero register: req 0 valid with addr=0, data=32'h1234 → req_ready[0]=1. Next cycle wr_en=0, grant_id=0. rr_ptr advances, so with 0 and 1 both valid the next grant goes to 1.
5. Flush: all valid with rr_ptr=2, flush=1 for one cycle → req_ready=0, next-cycle wr_en=0, conflict_cnt unchanged. Next grant (flush=0) goes to requester 0.
6. Saturation: with CNT_W=4, hold two requests for 20 cycles → conflict_cnt reaches 4'hF and holds; no wrap to 0.
